// File: rtl/spi_slave_rx_pkg.sv
// Shared constants for the SPI slave receiver: mode codes, FSM state codes and default width.
package spi_slave_rx_pkg;

    localparam int unsigned DefaultWidth = 8;

    localparam logic [1:0] Mode0 = 2'b00;
    localparam logic [1:0] Mode1 = 2'b01;
    localparam logic [1:0] Mode2 = 2'b10;
    localparam logic [1:0] Mode3 = 2'b11;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StShift = 2'd2;

    // Data is sampled on the rising sclk edge whenever CPOL equals CPHA.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return (mode == Mode0) || (mode == Mode3);
    endfunction

endpackage

// File: rtl/spi_slave_rx_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection taken from the synchronized level.
module spi_sync_edge #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {Stages{rst_val_i}};
            prev_q <= rst_val_i;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign rise_o = sync_q[Stages-1] & ~prev_q;
    assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave: full-duplex shift engine, transmit holding register and frame status pulses.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             mainclk_i,
    input  logic             reset_i,
    input  logic [1:0]       spi_mode_i,
    input  logic             sclk_i,
    input  logic             select_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             miso_oe_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             finish_o,
    output logic             underrun_o,
    output logic             abort_o
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic sclk_rise, sclk_fall, sel_rise, sel_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s, samp_rise, sample_edge, shift_edge;

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             finish_q, finish_d;
    logic             underrun_q, underrun_d;
    logic             abort_q, abort_d;
    logic             empty_pend_q, empty_pend_d;
    logic             done_q, done_d;

    spi_sync_edge #(.Stages(SYNC_STAGES)) u_sclk_sync (
        .clk_i     (mainclk_i),
        .rst_i     (reset_i),
        .rst_val_i (spi_mode_i[1]),
        .d_i       (sclk_i),
        .rise_o    (sclk_rise),
        .fall_o    (sclk_fall)
    );

    spi_sync_edge #(.Stages(SYNC_STAGES)) u_sel_sync (
        .clk_i     (mainclk_i),
        .rst_i     (reset_i),
        .rst_val_i (1'b1),
        .d_i       (select_i),
        .rise_o    (sel_rise),
        .fall_o    (sel_fall)
    );

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign samp_rise   = sample_on_rise(mode_q);
    assign sample_edge = samp_rise ? sclk_rise : sclk_fall;
    assign shift_edge  = samp_rise ? sclk_fall : sclk_rise;

    // The holding register is free again in the LOAD cycle, so a same-cycle write is accepted.
    assign tx_ready_o = !hold_full_q || (state_q == StLoad);
    assign miso_oe_o  = (state_q != StIdle);
    assign miso_o     = miso_oe_o & tx_shift_q[WIDTH-1];
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign finish_o   = finish_q;
    assign underrun_o = underrun_q;
    assign abort_o    = abort_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        finish_d     = 1'b0;
        underrun_d   = 1'b0;
        abort_d      = 1'b0;
        empty_pend_d = empty_pend_q;
        done_d       = done_q;

        if (state_q == StIdle) begin
            mode_d = spi_mode_i;
        end

        case (state_q)
            StIdle: begin
                if (sel_fall) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            StLoad: begin
                tx_shift_d   = hold_full_q ? hold_q : '0;
                empty_pend_d = !hold_full_q;
                hold_full_d  = 1'b0;
                state_d      = StShift;
            end
            StShift: begin
                if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    // Underrun is reported once the frame really starts, not at the idle reload.
                    if (cnt_q == '0 && empty_pend_q) begin
                        underrun_d   = 1'b1;
                        empty_pend_d = 1'b0;
                    end
                    if (cnt_q == CntLast) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = StLoad;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (shift_edge && cnt_q != '0) begin
                    // No shift before the first sample: the MSB is already on miso.
                    tx_shift_d = tx_shift_q << 1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tx_valid_i && tx_ready_o) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        if (sel_rise && state_q != StIdle) begin
            state_d      = StIdle;
            cnt_d        = '0;
            rx_shift_d   = '0;
            empty_pend_d = 1'b0;
            abort_d      = (cnt_q != '0);
            finish_d     = done_q;
        end
    end

    always_ff @(posedge mainclk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            mode_q       <= spi_mode_i;
            cnt_q        <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            finish_q     <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
            empty_pend_q <= 1'b0;
            done_q       <= 1'b0;
            mosi_sync_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            finish_q     <= finish_d;
            underrun_q   <= underrun_d;
            abort_q      <= abort_d;
            empty_pend_q <= empty_pend_d;
            done_q       <= done_d;
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed vector table, hand-written corner sequences, random frames.
module tb_spi_slave_rx;
    import spi_slave_rx_pkg::*;

    logic       mainclk = 1'b0;
    logic       reset;
    logic [1:0] spi_mode;
    logic       sclk, select, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, finish, underrun, abort;

    spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .mainclk_i  (mainclk),
        .reset_i    (reset),
        .spi_mode_i (spi_mode),
        .sclk_i     (sclk),
        .select_i   (select),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .miso_oe_o  (miso_oe),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .finish_o   (finish),
        .underrun_o (underrun),
        .abort_o    (abort)
    );

    always #5 mainclk = ~mainclk;

    int checks = 0;
    int errors = 0;
    int n_rxv = 0, n_fin = 0, n_und = 0, n_abt = 0;
    int d_rxv, d_fin, d_und, d_abt;
    bit accept_seen;

    // Pulse counters: a pulse stuck high counts once per cycle.
    always @(negedge mainclk) begin
        if (rx_valid) n_rxv <= n_rxv + 1;
        if (finish)   n_fin <= n_fin + 1;
        if (underrun) n_und <= n_und + 1;
        if (abort)    n_abt <= n_abt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge mainclk);
            n++;
        end
        check("load_ready", 32'(tx_ready), 32'd1);
        @(negedge mainclk);
        tx_valid = 1'b0;
    endtask

    task automatic accept_watch();
        accept_seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge mainclk);
            if (tx_ready) begin
                @(negedge mainclk);
                accept_seen = 1'b1;
                break;
            end
        end
        tx_valid = 1'b0;
    endtask

    // Master side of one frame (or the first nbits of it), MSB first.
    task automatic xfer(input logic [1:0] mode, input logic [7:0] mo, input int nbits,
                        input int half, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        mi   = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                repeat (half) @(negedge mainclk);
                mi[i] = miso;
                sclk  = ~cpol;
                repeat (half) @(negedge mainclk);
                sclk  = cpol;
            end else begin
                repeat (half) @(negedge mainclk);
                sclk = ~cpol;
                mosi = mo[i];
                repeat (half) @(negedge mainclk);
                mi[i] = miso;
                sclk  = cpol;
            end
        end
    endtask

    // One select-low transaction of nfr frames; the last frame carries last_bits bits.
    task automatic do_txn(input logic [1:0] mode, input logic [31:0] mo, input int nfr,
                          input bit load, input logic [7:0] txb, input int last_bits,
                          input int half, output logic [31:0] mi);
        int b_rxv, b_fin, b_und, b_abt, nb;
        logic [7:0] byte_mi;
        mi       = '0;
        spi_mode = mode;
        sclk     = mode[1];
        mosi     = 1'b0;
        repeat (8) @(negedge mainclk);
        if (load) load_tx(txb);
        b_rxv = n_rxv; b_fin = n_fin; b_und = n_und; b_abt = n_abt;
        select = 1'b0;
        repeat (2 * half) @(negedge mainclk);
        check("miso_oe_active", 32'(miso_oe), 32'd1);
        for (int f = 0; f < nfr; f++) begin
            nb = (f == nfr - 1) ? last_bits : 8;
            xfer(mode, mo[8*(3-f) +: 8], nb, half, byte_mi);
            mi[8*(3-f) +: 8] = byte_mi;
        end
        repeat (half) @(negedge mainclk);
        select = 1'b1;
        repeat (4 * half) @(negedge mainclk);
        check("miso_oe_idle", 32'({miso_oe, miso}), 32'd0);
        d_rxv = n_rxv - b_rxv; d_fin = n_fin - b_fin;
        d_und = n_und - b_und; d_abt = n_abt - b_abt;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] mo;
        logic [7:0] txb;
        bit         load;
        int         bits;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_rxv;
        int         exp_und;
        int         exp_abt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] mi, mo;
        logic [1:0]  rmode;
        logic [7:0]  txb, fb, model_rx;
        int          nfr, lb, half, bits, exp_rxv, exp_und;
        bit          load, got_tx;

        vecs[0] = '{Mode0, 8'h3C, 8'hA5, 1'b1, 8, 8'h3C, 8'hA5, 1, 0, 0};
        vecs[1] = '{Mode1, 8'hF0, 8'h5A, 1'b1, 8, 8'hF0, 8'h5A, 1, 0, 0};
        vecs[2] = '{Mode2, 8'hF0, 8'hC3, 1'b1, 8, 8'hF0, 8'hC3, 1, 0, 0};
        vecs[3] = '{Mode0, 8'h55, 8'h00, 1'b0, 5, 8'hF0, 8'h00, 0, 1, 1};
        vecs[4] = '{Mode0, 8'h69, 8'h96, 1'b1, 8, 8'h69, 8'h96, 1, 0, 0};
        vecs[5] = '{Mode3, 8'h12, 8'h00, 1'b0, 8, 8'h12, 8'h00, 1, 1, 0};

        reset = 1'b1; spi_mode = Mode0; sclk = 1'b0; select = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(negedge mainclk);
        check("reset_outputs", 32'({miso, miso_oe, rx_valid, finish, underrun, abort}), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_txn(vecs[v].mode, {vecs[v].mo, 24'h0}, 1, vecs[v].load, vecs[v].txb,
                   vecs[v].bits, 4, mi);
            check($sformatf("vec%0d_miso", v), 32'(mi[31:24]), 32'(vecs[v].exp_miso));
            check($sformatf("vec%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].exp_rx));
            check($sformatf("vec%0d_rx_valid", v), 32'(d_rxv), 32'(vecs[v].exp_rxv));
            check($sformatf("vec%0d_finish", v), 32'(d_fin), 32'(vecs[v].exp_rxv));
            check($sformatf("vec%0d_underrun", v), 32'(d_und), 32'(vecs[v].exp_und));
            check($sformatf("vec%0d_abort", v), 32'(d_abt), 32'(vecs[v].exp_abt));
        end

        // Back-to-back Mode3 frames with a single holding-register load.
        do_txn(Mode3, 32'h817E_0000, 2, 1'b1, 8'hA5, 8, 4, mi);
        check("b2b_miso0", 32'(mi[31:24]), 32'hA5);
        check("b2b_miso1", 32'(mi[23:16]), 32'h00);
        check("b2b_rx_data", 32'(rx_data), 32'h7E);
        check("b2b_rx_valid", 32'(d_rxv), 32'd2);
        check("b2b_underrun", 32'(d_und), 32'd1);
        check("b2b_finish", 32'(d_fin), 32'd1);

        // Reset in the middle of a frame.
        spi_mode = Mode0; sclk = 1'b0;
        repeat (8) @(negedge mainclk);
        d_abt = n_abt;
        select = 1'b0;
        repeat (8) @(negedge mainclk);
        xfer(Mode0, 8'hFF, 3, 4, txb);
        load_tx(8'h44);
        check("mid_tx_ready", 32'(tx_ready), 32'd0);
        reset = 1'b1;
        @(negedge mainclk);
        check("rst_outputs", 32'({miso, miso_oe, rx_valid, finish, underrun, abort}), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge mainclk);
        select = 1'b1;
        repeat (16) @(negedge mainclk);
        check("rst_no_abort", 32'(n_abt - d_abt), 32'd0);
        do_txn(Mode0, 32'hB700_0000, 1, 1'b0, 8'h00, 8, 4, mi);
        check("post_rst_rx", 32'(rx_data), 32'hB7);
        check("post_rst_miso", 32'(mi[31:24]), 32'h00);
        check("post_rst_rx_valid", 32'(d_rxv), 32'd1);

        // Holding register full with tx_valid held, then accepted during LOAD.
        load_tx(8'h11);
        tx_data = 8'h22; tx_valid = 1'b1;
        repeat (6) @(negedge mainclk);
        check("hold_not_ready", 32'(tx_ready), 32'd0);
        fork
            accept_watch();
        join_none
        do_txn(Mode0, 32'hC1C2_0000, 2, 1'b0, 8'h00, 8, 4, mi);
        got_tx = accept_seen;
        check("hold_accepted", 32'(got_tx), 32'd1);
        check("hold_miso0", 32'(mi[31:24]), 32'h11);
        check("hold_miso1", 32'(mi[23:16]), 32'h22);
        check("hold_underrun", 32'(d_und), 32'd0);
        check("hold_rx_data", 32'(rx_data), 32'hC2);

        // Random transactions against a frame-level model.
        model_rx = 8'hC2;
        for (int t = 0; t < 12; t++) begin
            rmode = 2'($urandom_range(0, 3));
            nfr   = int'($urandom_range(1, 3));
            mo    = $urandom;
            load  = 1'($urandom_range(0, 1));
            txb   = 8'($urandom);
            lb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            half  = int'($urandom_range(4, 6));
            do_txn(rmode, mo, nfr, load, txb, lb, half, mi);
            exp_rxv = 0;
            exp_und = 0;
            for (int f = 0; f < nfr; f++) begin
                bits = (f == nfr - 1) ? lb : 8;
                fb   = mo[8*(3-f) +: 8];
                if (!(f == 0 && load)) exp_und++;
                if (bits == 8) begin
                    exp_rxv++;
                    model_rx = fb;
                    check($sformatf("rnd%0d_miso%0d", t, f), 32'(mi[8*(3-f) +: 8]),
                          32'((f == 0 && load) ? txb : 8'h00));
                end
            end
            check($sformatf("rnd%0d_rx_data", t), 32'(rx_data), 32'(model_rx));
            check($sformatf("rnd%0d_rx_valid", t), 32'(d_rxv), 32'(exp_rxv));
            check($sformatf("rnd%0d_finish", t), 32'(d_fin), 32'((exp_rxv > 0) ? 1 : 0));
            check($sformatf("rnd%0d_underrun", t), 32'(d_und), 32'(exp_und));
            check($sformatf("rnd%0d_abort", t), 32'(d_abt), 32'((lb < 8) ? 1 : 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter WIDTH, default 8, frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk/select/mosi.
REQ-003 mainclk  input  1  system clock; all logic rising-edge, single domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 spi_mode  input  2  {CPOL,CPHA}; 00=Mode0, 01=Mode1, 10=Mode2, 11=Mode3; sampled only while select is high.
REQ-006 sclk  input  1  serial clock from master; asynchronous to mainclk.
REQ-007 select  input  1  chip select, active-low.
REQ-008 mosi  input  1  serial data from master.
REQ-009 miso  output  1  serial data to master.
REQ-010 miso_oe  output  1  miso drive enable; high only while select is low.
REQ-011 tx_data  input  WIDTH  next byte to transmit.
REQ-012 tx_valid  input  1  tx_data valid.
REQ-013 tx_ready  output  1  transmit holding register empty.
REQ-014 rx_data  output  WIDTH  last complete received frame.
REQ-015 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-016 finish  output  1  one-cycle pulse on select rising edge after at least one complete frame.
REQ-017 underrun  output  1  one-cycle pulse: frame started with empty holding register.
REQ-018 abort  output  1  one-cycle pulse: select deasserted mid-frame.

Function
REQ-019 sclk, select and mosi SHALL pass through SYNC_STAGES flops; edges detected from the last two stages; input-to-detected-edge latency SYNC_STAGES+1 cycles.
REQ-020 Supported sclk: high and low phases each at least 4 mainclk periods (sclk <= mainclk/8).
REQ-021 Leading edge = sclk transition away from CPOL level; trailing edge = return to CPOL level.
REQ-022 CPHA=0: sample mosi on leading edge, shift miso on trailing edge; first bit driven within 1 cycle of detected select fall.
REQ-023 CPHA=1: shift miso on leading edge (first bit on first leading edge), sample on trailing edge.
REQ-024 Bit order MSB first for both directions.
REQ-025 FSM states IDLE, LOAD, SHIFT; IDLE->LOAD on detected select fall; LOAD->SHIFT after 1 cycle; SHIFT->LOAD after WIDTH sample edges while select low; any state->IDLE on detected select rise.
REQ-026 LOAD: if holding register full, copy it to tx shift register and set tx_ready; else load all-zeros and pulse underrun.
REQ-027 Holding register accepts tx_data when tx_valid && tx_ready; tx_ready falls the next cycle; accept and LOAD-copy in the same cycle both take effect (copy old, store new).
REQ-028 Bit counter counts sample edges 0..WIDTH-1, wraps to 0 on frame completion; back-to-back frames need no select toggle.
REQ-029 After the WIDTH-th sample edge, rx_data updates and rx_valid pulses on the following cycle.
REQ-030 Select rise with bit counter nonzero: discard partial frame, pulse abort, no rx_valid, holding register untouched.
REQ-031 miso holds the current tx shift-register MSB; 0 while miso_oe low.
REQ-032 spi_mode changes while select low are ignored until next IDLE.

Reset
REQ-033 Reset SHALL force: state IDLE, bit counter 0, shift registers 0, holding register empty, tx_ready 1, rx_data 0, miso 0, miso_oe 0, rx_valid/finish/underrun/abort 0, synchronizer flops to idle (sclk=CPOL of current spi_mode, select=1, mosi=0).
REQ-034 Reset asserted mid-frame discards the frame without abort pulse; first frame after reset requires a fresh select fall.

Structure
REQ-035 Shared package holds mode encodings (Mode0..Mode3), FSM state encodings and default WIDTH.
REQ-036 One sub-module spi_sync_edge: synchronizer plus rise/fall detect, instantiated for sclk and select (mosi uses synchronizer only).

Verification
REQ-037 Mode0, tx_data=0xA5 loaded, master sends 0x3C at mainclk/8 -> miso 10100101, rx_data=0x3C, one rx_valid, finish after select rise.
REQ-038 Mode3, two back-to-back frames 0x81, 0x7E with one holding-register load -> rx_valid twice, second miso frame 0x00, underrun pulse once.
REQ-039 Mode1 and Mode2 each send 0xF0 -> rx_data=0xF0, miso first bit on first leading edge.
REQ-040 Select rise after 5 bits -> abort pulse, no rx_valid, rx_data unchanged, next full frame correct.
REQ-041 Reset asserted at bit 3 -> all outputs at reset values next cycle, no abort, following frame correct.
REQ-042 tx_valid held high with tx_ready low -> no overwrite; accept coincident with LOAD -> both bytes sent in order.
